// File: rtl/pixel_plot_sink_pkg.sv
// Shared definitions for the pixel-plot sink: framebuffer geometry, colour
// encoding, controller state encoding, the buffered plot request format and
// the framebuffer address helper.
package pixel_plot_sink_pkg;

    localparam int H_RES    = 160;
    localparam int V_RES    = 120;
    localparam int FB_SIZE  = H_RES * V_RES;
    localparam int FB_AW    = 15;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'd0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        WRITE,
        CLEAR
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } pixel_req_t;

    localparam int REQ_W = $bits(pixel_req_t);

    // y*160 + x as shift-and-add; only meaningful for in-range coordinates,
    // whose largest address (19199) fits in FB_AW bits without wrapping.
    function automatic logic [FB_AW-1:0] fb_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
        logic [FB_AW-1:0] y_ext;
        y_ext = {8'b0, y};
        return (y_ext << 7) + (y_ext << 5) + {7'b0, x};
    endfunction

endpackage

// File: rtl/pixel_plot_sink_fifo.sv
// plot_fifo: synchronous FIFO buffering plot requests in front of the
// framebuffer controller. Head data is presented combinationally; a pop
// advances to the next entry on the clock edge.
// Ports:
//   clock, resetn  clock and asynchronous active-low reset
//   push, push_data  write an entry (caller guarantees not full)
//   pop             discard the head entry (caller guarantees not empty)
//   head_data       current head entry
//   count           number of stored entries, 0..DEPTH
//   empty           count == 0
module plot_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // NOTE: every signal written here is given a value before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Power-of-two depth: the pointers wrap by plain overflow.
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);

endmodule

// File: rtl/pixel_plot_sink.sv
// pixel_plot_sink: receives plot requests from the object datapaths, buffers
// them, and writes them into a 160x120 3-bit framebuffer through a
// synchronous-read RAM port, flagging colour collisions on the way.
// Ports:
//   clock, resetn            clock and asynchronous active-low reset
//   plot, x, y, colour       pixel write request, taken when ready=1
//   ready                    request accepted this cycle
//   clear                    pulse: blank the framebuffer once the queue drains
//   hit_clr                  pulse: clear hit, hit_x, hit_y and dropped
//   mem_addr/wdata/we/rdata  framebuffer port; rdata lags addr by one cycle
//   busy                     work queued, in flight, or a clear outstanding
//   hit, hit_x, hit_y        sticky collision flag and first-collision coords
//   dropped                  sticky: an out-of-range request was discarded
module pixel_plot_sink
    import pixel_plot_sink_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                plot,
    input  logic [X_W-1:0]      x,
    input  logic [Y_W-1:0]      y,
    input  logic [COLOUR_W-1:0] colour,
    output logic                ready,
    input  logic                clear,
    input  logic                hit_clr,
    output logic [FB_AW-1:0]    mem_addr,
    output logic [COLOUR_W-1:0] mem_wdata,
    output logic                mem_we,
    input  logic [COLOUR_W-1:0] mem_rdata,
    output logic                busy,
    output logic                hit,
    output logic [X_W-1:0]      hit_x,
    output logic [Y_W-1:0]      hit_y,
    output logic                dropped
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FB_AW-1:0] FB_LAST = FB_AW'(FB_SIZE - 1);

    logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [REQ_W-1:0] fifo_head;
    logic [CNT_W-1:0] fifo_count;
    pixel_req_t       head;
    logic             head_in_range;
    logic             collision;

    state_t                state_q, state_d;
    pixel_req_t            cur_q, cur_d;
    logic [FB_AW-1:0]      mem_addr_q, mem_addr_d;
    logic [COLOUR_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  hit_q, hit_d;
    logic [X_W-1:0]        hit_x_q, hit_x_d;
    logic [Y_W-1:0]        hit_y_q, hit_y_d;
    logic                  dropped_q, dropped_d;
    logic                  clear_pend_q, clear_pend_d;

    plot_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_plot_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (fifo_push),
        .push_data ({x, y, colour}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign head          = pixel_req_t'(fifo_head);
    assign head_in_range = (head.x < X_W'(H_RES)) && (head.y < Y_W'(V_RES));
    assign fifo_full     = (fifo_count == CNT_W'(FIFO_DEPTH));

    // A pending or running clear closes the input so the sweep is the last
    // thing written; requests already queued drain first.
    assign ready     = !fifo_full && !clear_pend_q;
    assign fifo_push = plot && ready;
    assign busy      = !fifo_empty || (state_q != IDLE) || clear_pend_q;

    // mem_rdata holds the stored pixel while in CHECK.
    assign collision = (cur_q.colour != COLOUR_BLACK) &&
                       (mem_rdata    != COLOUR_BLACK) &&
                       (mem_rdata    != cur_q.colour);

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        hit_d        = hit_q;
        hit_x_d      = hit_x_q;
        hit_y_d      = hit_y_q;
        dropped_d    = dropped_q;
        clear_pend_d = clear_pend_q | clear;
        fifo_pop     = 1'b0;

        if (hit_clr) begin
            hit_d     = 1'b0;
            hit_x_d   = '0;
            hit_y_d   = '0;
            dropped_d = 1'b0;
        end

        case (state_q)
            // WRITE finishes the current pixel this cycle, so it can start
            // the next one exactly like IDLE, keeping 3 cycles per pixel.
            IDLE, WRITE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head_in_range) begin
                        state_d    = FETCH;
                        cur_d      = head;
                        mem_addr_d = fb_addr(head.x, head.y);
                    end else begin
                        state_d   = IDLE;
                        dropped_d = 1'b1;
                    end
                end else if (clear_pend_q) begin
                    state_d     = CLEAR;
                    mem_addr_d  = '0;
                    mem_wdata_d = COLOUR_BLACK;
                    mem_we_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                state_d = CHECK;
            end
            CHECK: begin
                // A collision overrides a coincident hit_clr; coordinates
                // latch only for the first collision since the flag was clear.
                if (collision) begin
                    hit_d = 1'b1;
                    if (!hit_q || hit_clr) begin
                        hit_x_d = cur_q.x;
                        hit_y_d = cur_q.y;
                    end
                end
                state_d     = WRITE;
                mem_we_d    = 1'b1;
                mem_wdata_d = cur_q.colour;
            end
            CLEAR: begin
                // mem_addr_q doubles as the sweep counter.
                if (mem_addr_q == FB_LAST) begin
                    state_d      = IDLE;
                    clear_pend_d = 1'b0;
                end else begin
                    mem_addr_d = mem_addr_q + 1'b1;
                    mem_we_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            hit_q        <= 1'b0;
            hit_x_q      <= '0;
            hit_y_q      <= '0;
            dropped_q    <= 1'b0;
            clear_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            hit_q        <= hit_d;
            hit_x_q      <= hit_x_d;
            hit_y_q      <= hit_y_d;
            dropped_q    <= dropped_d;
            clear_pend_q <= clear_pend_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign hit       = hit_q;
    assign hit_x     = hit_x_q;
    assign hit_y     = hit_y_q;
    assign dropped   = dropped_q;

endmodule
